dmem_bus_ctrl: RTL

- Multi-cycle data-memory controller directly downstream of the memory stage.
- Accepts the stage's access request: enable, load/store, address, aligned store data and byte mask.
- Drives a req/ack data bus, stalls the core while the access is outstanding, and returns raw load words to the stage's `wrap_load_in`.
- Owns bus timeout detection and the access-fault indication.

---
 rtl/dmem_bus_ctrl_pkg.sv | 21 ++
 rtl/dmem_bus_ctrl_timeout.sv | 41 ++++
 rtl/dmem_bus_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dmem_bus_ctrl_pkg.sv
// ============================================================================
//  Module   : dmem_bus_ctrl_pkg
//  Brief    : Shared state encodings and constants for the data-memory bus
//             controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_bus_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } dmem_state_e;

   localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/dmem_bus_ctrl_timeout.sv
// ============================================================================
//  Module   : dmem_timeout
//  Brief    : Clear/enable saturating counter flagging the last permitted
//             request cycle before a bus access is abandoned.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_timeout #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != C_LIMIT)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // The count holds completed unacked cycles, so the TIMEOUT-th request
   // cycle is the one where it equals TIMEOUT-1.
   assign o_expired = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/dmem_bus_ctrl.sv
// ============================================================================
//  Module   : dmem_bus_ctrl
//  Brief    : Multi-cycle req/ack data-memory controller that stalls the core
//             while an access is outstanding and reports access faults.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bus_ctrl
   import dmem_bus_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        load,
   input  logic        store,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  masking,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic        bus_err,
   input  logic [31:0] bus_rdata
);

   dmem_state_e r_state;
   dmem_state_e w_state_nxt;
   logic        w_valid;
   logic        w_expired;
   logic        w_cnt_clr;
   logic        w_cnt_en;
   logic        r_fault_latched;
   logic        w_unused_addr;

   assign w_valid       = mem_en && (load || store);
   assign w_cnt_clr     = (r_state == ST_IDLE) && w_valid;
   assign w_cnt_en      = (r_state == ST_REQ) && !bus_ack;
   assign fault         = (r_state == ST_DONE) && r_fault_latched;
   assign w_unused_addr = ^addr[1:0];

   dmem_timeout #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_cnt_clr),
      .i_en      (w_cnt_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      stall       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Gated by reset so the core is released while reset is held.
            stall = w_valid && rst;
            if (w_valid) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            stall = 1'b1;
            if (bus_ack || w_expired) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata           <= '0;
         bus_req         <= 1'b0;
         bus_we          <= 1'b0;
         bus_addr        <= '0;
         bus_be          <= '0;
         bus_wdata       <= '0;
         r_fault_latched <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_fault_latched <= 1'b0;
               if (w_valid) begin
                  bus_req   <= 1'b1;
                  bus_we    <= store;
                  bus_addr  <= {addr[31:2], 2'b00};
                  bus_wdata <= wdata;
                  bus_be    <= store ? masking : BE_ALL;
               end
            end
            ST_REQ: begin
               // An ack in the expiry cycle completes the access normally.
               if (bus_ack) begin
                  bus_req         <= 1'b0;
                  r_fault_latched <= bus_err;
                  if (!bus_err && !bus_we) begin
                     rdata <= bus_rdata;
                  end
               end else if (w_expired) begin
                  bus_req         <= 1'b0;
                  r_fault_latched <= 1'b1;
                  rdata           <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire
